// File: rtl/cache_access_arbiter.sv
// Cache access arbiter: serializes D/I/S/M requests onto the single L1
// lookup port, issues dirty-victim writebacks, expands clear into a per-set
// sweep and returns one response per accepted command.
module cache_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int OFFSET_W   = 6,
  parameter int SETS       = 16384,
  parameter int SNOOP_RUN  = 4,
  parameter int LK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [3:0]        d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [3:0]        s_cmd,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [3:0]        m_cmd,
  output logic              lk_valid,
  output logic [3:0]        lk_cmd,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_done,
  input  logic              lk_hit,
  input  logic              lk_evict_dirty,
  input  logic [ADDR_W-1:0] lk_victim_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ready,
  output logic              rsp_valid,
  output logic [1:0]        rsp_src,
  output logic              rsp_hit,
  output logic              busy,
  output logic              err
);

  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int RUN_W = $clog2(SNOOP_RUN + 1);
  localparam int TO_W  = $clog2(LK_TIMEOUT + 1);

  localparam logic [3:0] CMD_IFETCH = 4'd2;
  localparam logic [3:0] CMD_CLEAR  = 4'd8;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, WB, RESP, CLR_LAUNCH, CLR_WAIT
  } state_t;

  typedef enum logic [1:0] {SRC_D, SRC_I, SRC_S, SRC_M} src_t;

  state_t              state, state_nxt;
  src_t                src_q, grant_src, cpu_src;
  logic                grant_valid, cpu_any, snoop_block;
  logic                rr_ptr;        // 0: D wins a D/I tie, 1: I wins
  logic [RUN_W-1:0]    snoop_run;
  logic [SET_W-1:0]    set_ctr;
  logic [TO_W-1:0]     to_cnt;
  logic [3:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q, wb_addr_q;
  logic                hit_q;
  logic                lk_timeout, last_set, clearing;

  assign cpu_any     = d_valid | i_valid;
  assign cpu_src     = (d_valid && i_valid) ? (rr_ptr ? SRC_I : SRC_D)
                                            : (d_valid ? SRC_D : SRC_I);
  assign snoop_block = (snoop_run == RUN_W'(SNOOP_RUN)) && cpu_any;
  assign lk_timeout  = (to_cnt == TO_W'(LK_TIMEOUT - 1));
  assign last_set    = (set_ctr == SET_W'(SETS - 1));
  assign clearing    = (state == CLR_LAUNCH) || (state == CLR_WAIT);

  // Grant selection in IDLE: M > S > round-robin CPU, with snoop fairness.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    grant_valid = 1'b0;
    grant_src   = SRC_D;
    if (state == IDLE) begin
      if (m_valid) begin
        grant_valid = 1'b1;
        grant_src   = SRC_M;
      end else if (s_valid && !snoop_block) begin
        grant_valid = 1'b1;
        grant_src   = SRC_S;
      end else if (cpu_any) begin
        grant_valid = 1'b1;
        grant_src   = cpu_src;
      end
    end
  end

  assign d_ready = grant_valid && (grant_src == SRC_D);
  assign i_ready = grant_valid && (grant_src == SRC_I);
  assign s_ready = grant_valid && (grant_src == SRC_S);
  assign m_ready = grant_valid && (grant_src == SRC_M);

  // Next-state logic and per-state output pulses.
  always_comb begin
    state_nxt = state;
    lk_valid  = 1'b0;
    wb_valid  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (grant_valid)
              state_nxt = (grant_src == SRC_M && m_cmd == CMD_CLEAR) ? CLR_LAUNCH : LAUNCH;
      LAUNCH: begin
        lk_valid  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lk_done)         state_nxt = lk_evict_dirty ? WB : RESP;
        else if (lk_timeout) state_nxt = RESP;
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      CLR_LAUNCH: begin
        lk_valid  = 1'b1;
        state_nxt = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (lk_done)         state_nxt = last_set ? RESP : CLR_LAUNCH;
        else if (lk_timeout) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lk_cmd  = cmd_q;
  assign lk_addr = clearing ? (ADDR_W'(set_ctr) << OFFSET_W) : addr_q;
  assign wb_addr = wb_addr_q;
  assign rsp_src = src_q;
  assign rsp_hit = hit_q;
  assign busy    = (state != IDLE);

  // State register plus capture of request, lookup result and counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      src_q     <= SRC_D;
      rr_ptr    <= 1'b0;
      snoop_run <= '0;
      set_ctr   <= '0;
      to_cnt    <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      hit_q     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_valid) begin
          src_q   <= grant_src;
          hit_q   <= 1'b0;
          set_ctr <= '0;
          case (grant_src)
            SRC_D: begin cmd_q <= d_cmd;      addr_q <= d_addr; end
            SRC_I: begin cmd_q <= CMD_IFETCH; addr_q <= i_addr; end
            SRC_S: begin cmd_q <= s_cmd;      addr_q <= s_addr; end
            default: begin cmd_q <= m_cmd;    addr_q <= '0;     end
          endcase
          if (grant_src == SRC_S) begin
            if (snoop_run != RUN_W'(SNOOP_RUN)) snoop_run <= snoop_run + 1'b1;
          end else begin
            snoop_run <= '0;
          end
          if (grant_src == SRC_D) rr_ptr <= 1'b1;
          if (grant_src == SRC_I) rr_ptr <= 1'b0;
        end
        LAUNCH, CLR_LAUNCH: to_cnt <= '0;
        WAIT: begin
          if (lk_done) begin
            hit_q <= lk_hit;
            if (lk_evict_dirty) wb_addr_q <= lk_victim_addr;
          end else if (lk_timeout) begin
            err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CLR_WAIT: begin
          if (lk_done) begin
            if (!last_set) set_ctr <= set_ctr + 1'b1;
          end else if (lk_timeout) begin
            err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Self-checking bench for cache_access_arbiter: randomized requesters and a
// randomized lookup/writeback responder, checked every cycle against a
// transaction-level timeline model, plus directed grant-order scenarios.
module tb_cache_access_arbiter;

  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = 6;
  localparam int SETS       = 4;
  localparam int SNOOP_RUN  = 4;
  localparam int LK_TIMEOUT = 8;
  localparam int NEVER      = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_valid, d_ready, i_valid, i_ready, s_valid, s_ready, m_valid, m_ready;
  logic [3:0]        d_cmd, s_cmd, m_cmd, lk_cmd;
  logic [ADDR_W-1:0] d_addr, i_addr, s_addr, lk_addr, lk_victim_addr, wb_addr;
  logic              lk_valid, lk_done, lk_hit, lk_evict_dirty;
  logic              wb_valid, wb_ready, rsp_valid, rsp_hit, busy, err;
  logic [1:0]        rsp_src;

  always #5 clk = ~clk;

  cache_access_arbiter #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SETS(SETS),
    .SNOOP_RUN(SNOOP_RUN), .LK_TIMEOUT(LK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready), .d_cmd(d_cmd), .d_addr(d_addr),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_addr(s_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_cmd(m_cmd),
    .lk_valid(lk_valid), .lk_cmd(lk_cmd), .lk_addr(lk_addr),
    .lk_done(lk_done), .lk_hit(lk_hit), .lk_evict_dirty(lk_evict_dirty),
    .lk_victim_addr(lk_victim_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit),
    .busy(busy), .err(err)
  );

  typedef struct { int cyc; logic [3:0] cmd; logic [31:0] addr; } lk_exp_t;
  typedef struct { int cyc; logic hit; logic dirty; logic [31:0] victim; } done_t;

  lk_exp_t     lk_q[$];
  done_t       done_q[$];
  int          obs_log[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  // Requesters: a pending request holds its valid until accepted.
  bit          pend[4];
  logic [3:0]  req_cmd[4];
  logic [31:0] req_addr[4];
  int          gen_pct[4];

  // Arbitration model state.
  int          rr, srun;

  // Expected timeline of the transaction in flight (absolute cycle numbers).
  int          free_at, rsp_at, wb_from, wb_to, hold_from, hold_to, err_at;
  logic [3:0]  hold_cmd;
  logic [31:0] hold_addr, wb_addr_exp;
  int          rsp_src_exp;
  logic        rsp_hit_exp;

  // Forced parameters for the next accepted non-clear transaction.
  bit          frc_en, frc_hit, frc_dirty, frc_to;
  int          frc_k, frc_w;
  logic [31:0] frc_victim;
  bit          rst_req;

  // Observations taken from the DUT pins.
  int          last_acc_cyc, last_rsp_cyc, lk_cnt, wb_cnt;
  logic [1:0]  last_rsp_src;
  logic        last_rsp_hit;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    rr        = 0;
    srun      = 0;
    free_at   = cyc + 1;
    rsp_at    = -1;
    wb_from   = -1;
    wb_to     = -2;
    hold_from = -1;
    hold_to   = -2;
    err_at    = NEVER;
    lk_q.delete();
    done_q.delete();
  endfunction

  // Winner among pending requests: M first, then S unless the CPU side has
  // waited through SNOOP_RUN snoops, then D/I by the round-robin pointer.
  function automatic int pick(input bit [3:0] v);
    bit cpu;
    int cpu_w;
    cpu   = v[0] | v[1];
    cpu_w = (v[0] && v[1]) ? rr : (v[0] ? 0 : 1);
    if (v[3]) return 3;
    if (v[2] && !(srun == SNOOP_RUN && cpu)) return 2;
    if (cpu) return cpu_w;
    return -1;
  endfunction

  task automatic new_req(input int r);
    pend[r]     = 1'b1;
    req_addr[r] = $urandom;
    case (r)
      0: req_cmd[0] = 4'($urandom_range(0, 1));
      1: req_cmd[1] = 4'd2;
      2: req_cmd[2] = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd4;
      default: begin
        req_cmd[3]  = ($urandom_range(0, 1) != 0) ? 4'd8 : 4'd9;
        req_addr[3] = 32'h0;
      end
    endcase
  endtask

  // Build the expected timeline for a request accepted in the current cycle.
  task automatic schedule(input int g);
    int a, k, w, l, d;
    bit hit, dirty, to;
    logic [31:0] vic;
    lk_exp_t le;
    done_t   de;
    a = cyc;
    rsp_src_exp = g;
    wb_from = -1;
    wb_to   = -2;
    if (g == 3 && req_cmd[3] == 4'd8) begin
      l = a + 1;
      for (int j = 0; j < SETS; j++) begin
        le.cyc = l; le.cmd = 4'd8; le.addr = 32'(j) << OFFSET_W;
        lk_q.push_back(le);
        k = $urandom_range(1, 3);
        d = l + k;
        de.cyc = d; de.hit = 1'($urandom); de.dirty = 1'($urandom); de.victim = $urandom;
        done_q.push_back(de);
        l = d + 1;
      end
      rsp_at      = l;
      rsp_hit_exp = 1'b0;
      hold_from   = -1;
      hold_to     = -2;
    end else begin
      k     = $urandom_range(1, 6);
      hit   = 1'($urandom);
      dirty = ($urandom_range(0, 2) == 0);
      vic   = $urandom;
      w     = $urandom_range(0, 3);
      to    = ($urandom_range(0, 19) == 0);
      if (frc_en) begin
        k = frc_k; hit = frc_hit; dirty = frc_dirty; vic = frc_victim; w = frc_w; to = frc_to;
        frc_en = 1'b0;
      end
      le.cyc = a + 1; le.cmd = req_cmd[g]; le.addr = req_addr[g];
      lk_q.push_back(le);
      hold_from = a + 1;
      hold_cmd  = req_cmd[g];
      hold_addr = req_addr[g];
      if (to) begin
        hold_to     = a + 1 + LK_TIMEOUT;
        rsp_at      = hold_to + 1;
        rsp_hit_exp = 1'b0;
        if (err_at > rsp_at) err_at = rsp_at;
      end else begin
        d = a + 1 + k;
        de.cyc = d; de.hit = hit; de.dirty = dirty; de.victim = vic;
        done_q.push_back(de);
        hold_to = d;
        if (dirty) begin
          wb_from     = d + 1;
          wb_to       = d + 1 + w;
          wb_addr_exp = vic;
          rsp_at      = wb_to + 1;
        end else begin
          rsp_at = d + 1;
        end
        rsp_hit_exp = hit;
      end
    end
    free_at = rsp_at + 1;
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic cycle();
    bit [3:0]   vmask, rdy, rdy_exp;
    bit         idle, in_rst, exp_lk, in_wb;
    int         g;
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < 4; r++)
      if (!pend[r] && $urandom_range(0, 99) < gen_pct[r]) new_req(r);
    d_valid = pend[0]; d_cmd = req_cmd[0]; d_addr = req_addr[0];
    i_valid = pend[1]; i_addr = req_addr[1];
    s_valid = pend[2]; s_cmd = req_cmd[2]; s_addr = req_addr[2];
    m_valid = pend[3]; m_cmd = req_cmd[3];
    lk_done = 1'b0; lk_hit = 1'($urandom); lk_evict_dirty = 1'($urandom);
    lk_victim_addr = $urandom;
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      lk_done        = 1'b1;
      lk_hit         = done_q[0].hit;
      lk_evict_dirty = done_q[0].dirty;
      lk_victim_addr = done_q[0].victim;
      void'(done_q.pop_front());
    end else if (cyc >= free_at && $urandom_range(0, 7) == 0) begin
      lk_done = 1'b1;
    end
    in_wb    = (cyc >= wb_from && cyc <= wb_to);
    wb_ready = in_wb ? (cyc == wb_to) : 1'($urandom);
    in_rst   = rst_req;
    rst      = rst_req;
    rst_req  = 1'b0;

    @(negedge clk);
    idle   = (cyc >= free_at);
    exp_lk = (lk_q.size() > 0 && lk_q[0].cyc == cyc);
    check("lk_valid", lk_valid, exp_lk);
    if (exp_lk) begin
      check("lk_cmd", lk_cmd, lk_q[0].cmd);
      check("lk_addr", lk_addr, lk_q[0].addr);
      void'(lk_q.pop_front());
    end
    if (cyc >= hold_from && cyc <= hold_to) begin
      check("lk_cmd_hold", lk_cmd, hold_cmd);
      check("lk_addr_hold", lk_addr, hold_addr);
    end
    check("wb_valid", wb_valid, in_wb);
    if (in_wb) check("wb_addr", wb_addr, wb_addr_exp);
    check("rsp_valid", rsp_valid, cyc == rsp_at);
    if (cyc == rsp_at) begin
      check("rsp_src", rsp_src, rsp_src_exp);
      check("rsp_hit", rsp_hit, rsp_hit_exp);
    end
    check("busy", busy, !idle);
    check("err", err, cyc >= err_at);

    vmask   = {pend[3], pend[2], pend[1], pend[0]};
    rdy     = {m_ready, s_ready, i_ready, d_ready};
    g       = idle ? pick(vmask) : -1;
    rdy_exp = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("ready", rdy, rdy_exp);

    if (lk_valid) lk_cnt++;
    if (wb_valid) wb_cnt++;
    if (rsp_valid) begin
      last_rsp_cyc = cyc;
      last_rsp_src = rsp_src;
      last_rsp_hit = rsp_hit;
    end
    if (!in_rst) begin
      for (int i = 0; i < 4; i++)
        if (rdy[i] && vmask[i]) begin
          obs_log.push_back(i);
          last_acc_cyc = cyc;
          break;
        end
    end

    if (in_rst) begin
      model_reset();
    end else if (g >= 0) begin
      schedule(g);
      if (g == 2) srun = (srun < SNOOP_RUN) ? srun + 1 : SNOOP_RUN;
      else        srun = 0;
      if (g == 0) rr = 1;
      if (g == 1) rr = 0;
      pend[g] = 1'b0;
    end
  endtask

  // Run until nothing is pending and the next cycle is idle, bounded.
  task automatic run_until_idle(input string tag, input int bound);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (cyc + 1 >= free_at && !(pend[0] || pend[1] || pend[2] || pend[3])) begin
        drained = 1'b1;
        break;
      end
    end
    check(tag, drained, 1'b1);
  endtask

  task automatic collect_grants(input string tag, input int count, input int bound);
    for (int i = 0; i < bound && obs_log.size() < count; i++) cycle();
    check(tag, obs_log.size() >= count, 1'b1);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
  endtask

  initial begin
    int exp_di[4];
    int exp_sd[6];
    exp_di = '{0, 1, 0, 1};
    exp_sd = '{2, 2, 2, 2, 0, 2};
    rst = 1'b1;
    d_valid = 0; i_valid = 0; s_valid = 0; m_valid = 0;
    d_cmd = 0; s_cmd = 0; m_cmd = 0; d_addr = 0; i_addr = 0; s_addr = 0;
    lk_done = 0; lk_hit = 0; lk_evict_dirty = 0; lk_victim_addr = 0; wb_ready = 0;
    for (int r = 0; r < 4; r++) begin
      pend[r] = 1'b0; req_cmd[r] = 4'd0; req_addr[r] = 32'h0; gen_pct[r] = 0;
    end
    frc_en = 0; rst_req = 0;
    last_acc_cyc = 0; last_rsp_cyc = 0; lk_cnt = 0; wb_cnt = 0;
    last_rsp_src = 0; last_rsp_hit = 0;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state with no requests.
    repeat (3) cycle();

    // Single D read, immediate hit: accept, launch, wait, respond.
    pend[0] = 1; req_cmd[0] = 4'd0; req_addr[0] = 32'h0000_1040;
    frc_en = 1; frc_k = 1; frc_hit = 1; frc_dirty = 0; frc_to = 0; frc_w = 0; frc_victim = 0;
    run_until_idle("drain_read", 50);
    check("accept_to_rsp", last_rsp_cyc - last_acc_cyc, 3);
    check("read_rsp_src", last_rsp_src, 2'd0);
    check("read_rsp_hit", last_rsp_hit, 1'b1);
    cycle();

    // D write miss with dirty victim, writeback ready delayed three cycles.
    wb_cnt = 0;
    pend[0] = 1; req_cmd[0] = 4'd1; req_addr[0] = 32'h0000_2080;
    frc_en = 1; frc_k = 1; frc_hit = 0; frc_dirty = 1; frc_to = 0; frc_w = 3;
    frc_victim = 32'hABCD_0000;
    run_until_idle("drain_wb", 50);
    check("wb_hold_cycles", wb_cnt, 4);
    check("wb_rsp_hit", last_rsp_hit, 1'b0);

    // D and I continuously valid from reset: strict alternation.
    do_reset();
    obs_log.delete();
    gen_pct[0] = 100; gen_pct[1] = 100;
    collect_grants("di_grants", 4, 400);
    for (int i = 0; i < 4 && i < obs_log.size(); i++) check("di_order", obs_log[i], exp_di[i]);
    gen_pct[0] = 0; gen_pct[1] = 0;
    run_until_idle("drain_di", 200);

    // S and D continuously valid from reset: snoop run capped at SNOOP_RUN.
    do_reset();
    obs_log.delete();
    gen_pct[0] = 100; gen_pct[2] = 100;
    collect_grants("sd_grants", 6, 600);
    for (int i = 0; i < 6 && i < obs_log.size(); i++) check("sd_order", obs_log[i], exp_sd[i]);
    gen_pct[0] = 0; gen_pct[2] = 0;
    run_until_idle("drain_sd", 200);

    // Clear sweep over all sets.
    lk_cnt = 0;
    pend[3] = 1; req_cmd[3] = 4'd8; req_addr[3] = 32'h0;
    run_until_idle("drain_clear", 200);
    check("clear_lk_pulses", lk_cnt, SETS);
    check("clear_rsp_src", last_rsp_src, 2'd3);
    check("clear_len", (last_rsp_cyc - last_acc_cyc + 1) >= 2 * SETS + 2, 1'b1);

    // Randomized traffic with occasional mid-operation resets.
    gen_pct[0] = 25; gen_pct[1] = 25; gen_pct[2] = 15; gen_pct[3] = 8;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) rst_req = 1'b1;
      cycle();
    end
    gen_pct[0] = 0; gen_pct[1] = 0; gen_pct[2] = 0; gen_pct[3] = 0;
    run_until_idle("drain_random", 500);

    // Lookup never completes: timeout sets err, reset right after clears it.
    pend[0] = 1; req_cmd[0] = 4'd0; req_addr[0] = 32'h0000_3000;
    frc_en = 1; frc_k = 1; frc_hit = 1; frc_dirty = 0; frc_to = 1; frc_w = 0; frc_victim = 0;
    run_until_idle("drain_timeout", 50);
    check("timeout_err", err, 1'b1);
    check("timeout_rsp_hit", last_rsp_hit, 1'b0);
    do_reset();
    cycle();
    check("err_after_rst", err, 1'b0);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_access_arbiter.md
# cache_access_arbiter

Sequencer that owns the single lookup/update port of the split L1 cache (4-way instruction, 8-way data, MESI + LRU). It accepts trace commands from four requesters: CPU data, CPU instruction fetch, L2 snoop, and maintenance. It serializes them onto the cache lookup engine, drives dirty-victim writebacks, and returns one response per accepted command. Clear (n=8) is expanded here into a per-set sweep, so the cache datapath only ever sees single-set operations.

## Interface
- ADDR_W, 32, address width
- OFFSET_W, 6, line offset bits (64-byte lines)
- SETS, 16384, number of sets swept by clear; power of two
- SNOOP_RUN, 4, max consecutive snoop grants while a CPU request waits
- LK_TIMEOUT, 255, cycles allowed from lk_valid to lk_done
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- d_valid/d_ready  in/out  1  data request handshake; d_cmd in 4 (0 read, 1 write); d_addr in ADDR_W
- i_valid/i_ready  in/out  1  instruction fetch handshake (cmd 2); i_addr in ADDR_W
- s_valid/s_ready  in/out  1  snoop handshake; s_cmd in 4 (3 invalidate, 4 L2 read); s_addr in ADDR_W
- m_valid/m_ready  in/out  1  maintenance handshake; m_cmd in 4 (8 clear, 9 print)
- lk_valid  out  1  one-cycle pulse launching a lookup; lk_cmd out 4; lk_addr out ADDR_W
- lk_done  in  1  lookup complete; lk_hit in 1; lk_evict_dirty in 1; lk_victim_addr in ADDR_W (all sampled with lk_done)
- wb_valid  out  1  writeback request, held until wb_ready; wb_addr out ADDR_W
- rsp_valid  out  1  one-cycle response pulse; rsp_src out 2 (0 D, 1 I, 2 S, 3 M); rsp_hit out 1
- busy  out  1  high in every state except IDLE
- err  out  1  sticky lookup-timeout flag, cleared only by rst

## Operation
- States: IDLE, LAUNCH, WAIT, WB, RESP, CLR_LAUNCH, CLR_WAIT.
- IDLE grant priority is M > S > {D, I}. D and I use round-robin with a 1-bit pointer. The pointer starts at D after reset and flips to the loser after each D or I grant.
- Snoop fairness: snoop_run counts consecutive S grants. When snoop_run == SNOOP_RUN and d_valid or i_valid is set, the round-robin CPU winner is granted instead of S. Any non-S grant clears snoop_run. The counter saturates at SNOOP_RUN.
- Exactly one x_ready is high, only in IDLE, only for the granted requester, and combinationally from the x_valid inputs. On acceptance, cmd/addr/src are captured.
- Accepted D/I/S/M(9) commands go to LAUNCH. LAUNCH pulses lk_valid with the captured cmd/addr, then moves to WAIT.
- In WAIT:
  - lk_done with lk_evict_dirty=1 goes to WB, with wb_addr = lk_victim_addr.
  - Otherwise it goes to RESP.
  - lk_hit is latched in both cases.
- WB holds wb_valid until wb_valid && wb_ready, then goes to RESP.
- RESP pulses rsp_valid with the latched src/hit, then returns to IDLE.
- M(8), clear:
  - set_ctr starts at 0.
  - CLR_LAUNCH pulses lk_valid with lk_cmd=8 and lk_addr = set_ctr << OFFSET_W.
  - CLR_WAIT waits for lk_done. Writebacks are not issued during a clear.
  - If set_ctr == SETS-1, go to RESP with rsp_hit=0. Otherwise increment set_ctr and return to CLR_LAUNCH.
- Timeout: a counter runs in WAIT and CLR_WAIT. If it reaches LK_TIMEOUT without lk_done:
  - set err and go to RESP with rsp_hit=0;
  - an in-progress clear is abandoned.
- lk_done outside WAIT/CLR_WAIT is ignored.

## Timing
- Reset values: all x_ready=0, lk_valid=0, wb_valid=0, rsp_valid=0, busy=0, err=0, rr pointer=D, snoop_run=0, set_ctr=0, state IDLE.
- Minimum latency, accept to rsp_valid, with lk_done arriving the cycle after lk_valid: 4 cycles. The sequence is accept (IDLE) → LAUNCH → WAIT → RESP.
- Back-to-back throughput: a new request can be accepted the cycle after RESP.
- Clear takes at least 2×SETS + 2 cycles.
- Reset mid-operation: rst takes effect the next posedge from any state. It drops lk_valid/wb_valid/rsp_valid immediately and abandons any pending writeback or clear.
- Simultaneous x_valid in IDLE: only the winner sees x_ready. Losers must hold valid, and no request is dropped.
- Address/cmd outputs stay stable from LAUNCH until leaving WAIT. wb_addr stays stable while wb_valid is high.

## Test plan
- Single D read 0x0000_1040, lk_done+lk_hit=1 one cycle after lk_valid → rsp_valid 4 cycles after accept, rsp_src=0, rsp_hit=1, busy low again next cycle.
- D and I both valid continuously → grants alternate D, I, D, I; each gets rsp_src matching the grant.
- S valid continuously plus D valid, SNOOP_RUN=4 → grant order S,S,S,S,D,S…
- D write miss with lk_evict_dirty=1, lk_victim_addr=0xABCD_0000, wb_ready delayed 3 cycles → wb_valid held 4 cycles with wb_addr=0xABCD_0000, then rsp_hit=0.
- SETS=4, m_cmd=8 → four lk_valid pulses with lk_addr 0x000, 0x040, 0x080, 0x0C0, then one rsp_valid with rsp_src=3.
- lk_done never asserted, LK_TIMEOUT=8 → err=1 after 8 WAIT cycles, rsp_valid with rsp_hit=0; rst in the next cycle clears err and all outputs.
